// File: rtl/calc_fmt_pkg.sv
// Shared types, ASCII constants and digit-to-character helper for the
// calculator display formatters.
package calc_fmt_pkg;

  typedef enum logic [1:0] {
    FMT_DEC = 2'd0,
    FMT_HEX = 2'd1,
    FMT_BIN = 2'd2,
    FMT_RSV = 2'd3
  } fmt_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FORMAT = 2'd2
  } fmt_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Binary digits are passed as 4'd0/4'd1 and map the same way.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'h0, n};
    return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/ascii_number_formatter_if.sv
// Request/result bundle between the calculator datapath and the formatter.
interface ascii_number_formatter_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     value;
  logic [1:0]           mode;
  logic                 pad_en;
  logic [WIDTH*8-1:0]   ascii_out;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, value, mode, pad_en,
    input  ascii_out, busy, done, err
  );

  modport slave (
    input  start, value, mode, pad_en,
    output ascii_out, busy, done, err
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/ascii_number_formatter.sv
// Number-to-ASCII formatter: decimal (double-dabble, one bit per cycle),
// hex or binary, right-justified with optional leading-zero padding.
//
// state     | meaning
// ST_IDLE   | waiting for start; inputs latched on acceptance
// ST_CONV   | decimal only: WIDTH shift/add-3 steps
// ST_FORMAT | build string, register ascii_out, pulse done
module ascii_number_formatter
  import calc_fmt_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ascii_number_formatter_if.slave bus
);
  localparam int DEC_DIGITS = ((WIDTH * 1233) >> 12) + 1;
  localparam int HEX_DIGITS = WIDTH / 4;
  localparam int OUT_CHARS  = WIDTH;
  localparam int BCD_W      = DEC_DIGITS * 4;
  localparam int CW         = $clog2(WIDTH);

  fmt_state_t               state, state_nxt;
  logic [WIDTH-1:0]         val_q;
  logic [BCD_W-1:0]         bcd_q, bcd_adj;
  logic [CW-1:0]            bit_cnt;
  fmt_mode_t                mode_q;
  logic                     pad_q;
  logic [OUT_CHARS*8-1:0]   ascii_q, fmt_str;
  logic                     done_q, err_q;
  logic [OUT_CHARS*4-1:0]   dig_vec;
  int                       ndig;
  logic                     lead;
  logic [3:0]               d;

  for (genvar g = 0; g < DEC_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (.din(bcd_q[g*4 +: 4]), .dout(bcd_adj[g*4 +: 4]));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; non-decimal modes skip the conversion loop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = (fmt_mode_t'(bus.mode) == FMT_DEC) ? ST_CONV : ST_FORMAT;
      ST_CONV:   if (bit_cnt == '0) state_nxt = ST_FORMAT;
      ST_FORMAT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Input latch, double-dabble shift register and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      mode_q  <= FMT_DEC;
      pad_q   <= 1'b0;
      ascii_q <= {OUT_CHARS{PAD_CHAR}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start) begin
          val_q   <= bus.value;
          mode_q  <= fmt_mode_t'(bus.mode);
          pad_q   <= bus.pad_en;
          bcd_q   <= '0;
          bit_cnt <= CW'(WIDTH - 1);
        end
        ST_CONV: begin
          bcd_q   <= {bcd_adj[BCD_W-2:0], val_q[WIDTH-1]};
          val_q   <= val_q << 1;
          bit_cnt <= bit_cnt - CW'(1);
        end
        ST_FORMAT: begin
          ascii_q <= fmt_str;
          done_q  <= 1'b1;
          err_q   <= (mode_q == FMT_RSV);
        end
        default: ;
      endcase
    end
  end

  // String builder: per-position digits, then blank leading zeros from the top.
  always_comb begin
    fmt_str = {OUT_CHARS{PAD_CHAR}};
    dig_vec = '0;
    ndig    = 0;
    lead    = 1'b1;
    d       = '0;
    case (mode_q)
      FMT_DEC: begin
        dig_vec = {{(OUT_CHARS*4-BCD_W){1'b0}}, bcd_q};
        ndig    = DEC_DIGITS;
      end
      FMT_HEX: begin
        dig_vec = {{(OUT_CHARS*3){1'b0}}, val_q};
        ndig    = HEX_DIGITS;
      end
      FMT_BIN: begin
        for (int i = 0; i < OUT_CHARS; i++) dig_vec[i*4 +: 4] = {3'b000, val_q[i]};
        ndig = OUT_CHARS;
      end
      default: ;
    endcase
    if (mode_q == FMT_RSV) begin
      fmt_str[7:0] = ASCII_E;
    end else begin
      for (int i = OUT_CHARS - 1; i >= 0; i--) begin
        if (i < ndig) begin
          d = dig_vec[i*4 +: 4];
          // Char 0 is always printed so a zero value still shows "0".
          if (pad_q && lead && d == 4'd0 && i != 0) begin
            fmt_str[i*8 +: 8] = PAD_CHAR;
          end else begin
            fmt_str[i*8 +: 8] = nibble_to_ascii(d);
            lead = 1'b0;
          end
        end
      end
    end
  end

  assign bus.ascii_out = ascii_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ascii_number_formatter.sv
// Self-checking bench for ascii_number_formatter (WIDTH=16 and WIDTH=32 builds).
module tb_ascii_number_formatter;
  localparam logic [7:0] SP = 8'h20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascii_number_formatter_if #(.WIDTH(16)) bus16();
  ascii_number_formatter_if #(.WIDTH(32)) bus32();

  ascii_number_formatter #(.WIDTH(16), .PAD_CHAR(8'h20)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  ascii_number_formatter #(.WIDTH(32), .PAD_CHAR(8'h20)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0]  v;
    logic [1:0]   m;
    logic         p;
    int           lat;
    logic         e;
    logic [127:0] s;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: digits by repeated division, then leading-zero blanking.
  function automatic logic [127:0] ref_fmt(input logic [15:0] v, input logic [1:0] m, input logic p);
    logic [127:0] r;
    int unsigned x, base, nd;
    int unsigned dig[16];
    bit lead;
    r = {16{SP}};
    if (m == 2'd3) begin
      r[7:0] = "E";
      return r;
    end
    base = (m == 2'd0) ? 10 : (m == 2'd1) ? 16 : 2;
    nd   = (m == 2'd0) ? 5  : (m == 2'd1) ? 4  : 16;
    x = 32'(v);
    for (int i = 0; i < 16; i++) dig[i] = 0;
    for (int i = 0; i < int'(nd); i++) begin
      dig[i] = x % base;
      x = x / base;
    end
    lead = 1'b1;
    for (int i = int'(nd) - 1; i >= 0; i--) begin
      if (p && lead && dig[i] == 0 && i != 0) r[i*8 +: 8] = SP;
      else begin
        r[i*8 +: 8] = (dig[i] < 10) ? 8'(48 + dig[i]) : 8'(55 + dig[i]);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic pulse16(input logic [15:0] v, input logic [1:0] m, input logic p);
    bus16.start = 1'b1; bus16.value = v; bus16.mode = m; bus16.pad_en = p;
    @(posedge clk); #1;
    bus16.start  = 1'b0;
    bus16.value  = 16'($urandom);
    bus16.mode   = 2'($urandom_range(0, 3));
    bus16.pad_en = 1'($urandom_range(0, 1));
  endtask

  task automatic wait16(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (bus16.done !== 1'b1 && lat < 100) begin
      if (bus16.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus16.busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic run16(input string name, input logic [15:0] v, input logic [1:0] m, input logic p,
                       input int exp_lat, input logic exp_err, input logic [127:0] exp_s);
    int lat;
    logic bok;
    pulse16(v, m, p);
    wait16(lat, bok);
    check({name, " latency"}, 256'(lat), 256'(exp_lat));
    check({name, " ascii"}, 256'(bus16.ascii_out), 256'(exp_s));
    check({name, " err"}, 256'(bus16.err), 256'(exp_err));
    check({name, " busy"}, 256'(bok), 256'(1'b1));
  endtask

  int   lat;
  logic bok;
  logic seen;
  logic [15:0] rv;
  logic [1:0]  rm;
  logic        rp;

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus16.start = 0; bus16.value = 0; bus16.mode = 0; bus16.pad_en = 0;
    bus32.start = 0; bus32.value = 0; bus32.mode = 0; bus32.pad_en = 0;

    tbl[0] = '{16'd66,    2'd0, 1'b1, 17, 1'b0, {{14{SP}}, "66"}};
    tbl[1] = '{16'hBEEF,  2'd1, 1'b0, 1,  1'b0, {{12{SP}}, "BEEF"}};
    tbl[2] = '{16'h000A,  2'd2, 1'b1, 1,  1'b0, {{12{SP}}, "1010"}};
    tbl[3] = '{16'h000A,  2'd2, 1'b0, 1,  1'b0, {{12{"0"}}, "1010"}};
    tbl[4] = '{16'hFFFF,  2'd0, 1'b0, 17, 1'b0, {{11{SP}}, "65535"}};
    tbl[5] = '{16'd0,     2'd0, 1'b1, 17, 1'b0, {{15{SP}}, "0"}};
    tbl[6] = '{16'h1234,  2'd3, 1'b1, 1,  1'b1, {{15{SP}}, "E"}};
    tbl[7] = '{16'd66,    2'd0, 1'b0, 17, 1'b0, {{11{SP}}, "00066"}};
    tbl[8] = '{16'd0,     2'd1, 1'b0, 1,  1'b0, {{12{SP}}, "0000"}};
    tbl[9] = '{16'h00F0,  2'd1, 1'b1, 1,  1'b0, {{14{SP}}, "F0"}};

    repeat (3) @(posedge clk);
    #1;
    check("reset ascii", 256'(bus16.ascii_out), 256'({16{SP}}));
    check("reset busy", 256'(bus16.busy), 256'(1'b0));
    check("reset done", 256'(bus16.done), 256'(1'b0));
    check("reset err", 256'(bus16.err), 256'(1'b0));
    check("reset ascii32", 256'(bus32.ascii_out), {32{SP}});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run16($sformatf("vec%0d", i), tbl[i].v, tbl[i].m, tbl[i].p, tbl[i].lat, tbl[i].e, tbl[i].s);

    // Start while busy is ignored; start on the done cycle is accepted.
    pulse16(16'd66, 2'd0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    pulse16(16'd999, 2'd1, 1'b0);
    wait16(lat, bok);
    check("ignored start latency", 256'(lat + 5), 256'(17));
    check("ignored start ascii", 256'(bus16.ascii_out), 256'({{14{SP}}, "66"}));
    check("done cycle is high", 256'(bus16.done), 256'(1'b1));
    pulse16(16'd12345, 2'd0, 1'b0);
    wait16(lat, bok);
    check("back2back latency", 256'(lat), 256'(17));
    check("back2back ascii", 256'(bus16.ascii_out), 256'({{11{SP}}, "12345"}));

    // Reset in the middle of a decimal conversion.
    pulse16(16'd66, 2'd0, 1'b1);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst busy", 256'(bus16.busy), 256'(1'b0));
    check("midrst done", 256'(bus16.done), 256'(1'b0));
    check("midrst ascii", 256'(bus16.ascii_out), 256'({16{SP}}));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus16.done === 1'b1) seen = 1'b1;
    end
    check("midrst no done", 256'(seen), 256'(1'b0));
    check("midrst ascii held", 256'(bus16.ascii_out), 256'({16{SP}}));
    run16("post reset", 16'hFFFF, 2'd0, 1'b0, 17, 1'b0, {{11{SP}}, "65535"});

    // Randomized vectors against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom);
      rm = 2'($urandom_range(0, 3));
      rp = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rv = 16'($urandom_range(0, 20));
      run16($sformatf("rand%0d", i), rv, rm, rp, (rm == 2'd0) ? 17 : 1, (rm == 2'd3), ref_fmt(rv, rm, rp));
    end

    // WIDTH=32 decimal maximum.
    bus32.start = 1'b1; bus32.value = 32'd4294967295; bus32.mode = 2'd0; bus32.pad_en = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0; bus32.value = 32'd0;
    lat = 0;
    while (bus32.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w32 latency", 256'(lat), 256'(33));
    check("w32 ascii", bus32.ascii_out, {{22{SP}}, "4294967295"});
    check("w32 err", 256'(bus32.err), 256'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
